// File: rtl/adc_pkg.sv
// Shared types and sizing for the ADC scan scheduler.
// Channel pointers carry one extra bit so "past channel 15" is representable.
package adc_pkg;

    localparam int ADC_NUM_CH   = 16;
    localparam int ADC_CH_W     = 4;
    localparam int ADC_SAMPLE_W = 10;
    localparam int ADC_PTR_W    = ADC_CH_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT,
        DONE
    } adc_scan_state_t;

    // Pointer to the channel after ch; 15 maps to 16, which means none left.
    function automatic logic [ADC_PTR_W-1:0] adc_next_ptr(input logic [ADC_CH_W-1:0] ch);
        return {1'b0, ch} + ADC_PTR_W'(1);
    endfunction

endpackage

// File: rtl/adc_ch_finder.sv
// Combinational search for the lowest enabled channel at or above ptr.
// A ptr of 16 or more never finds anything.
module adc_ch_finder
    import adc_pkg::*;
(
    input  logic [ADC_NUM_CH-1:0] mask,
    input  logic [ADC_PTR_W-1:0]  ptr,
    output logic                  found,
    output logic [ADC_CH_W-1:0]   idx
);

    // Descending scan so the lowest qualifying channel is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int n = ADC_NUM_CH - 1; n >= 0; n--) begin
            if (mask[n] && (ADC_PTR_W'(n) >= ptr)) begin
                found = 1'b1;
                idx   = ADC_CH_W'(n);
            end
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Walks the enabled ADC channels, requests each from the AVR interface and
// captures one validated sample per channel into a 16-entry result bank.
//
// state  | meaning
// IDLE   | waiting for scan_start
// SELECT | pick the next enabled channel at or above ptr
// WAIT   | drop DISCARD stale samples, accept one, or time out
// DONE   | scan_done pulse; restart when continuous
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int DISCARD        = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADC_NUM_CH-1:0]   ch_enable,
    input  logic                    scan_start,
    input  logic                    scan_continuous,
    output logic [ADC_CH_W-1:0]     channel,
    input  logic                    new_sample,
    input  logic [ADC_SAMPLE_W-1:0] sample,
    input  logic [ADC_CH_W-1:0]     sample_channel,
    output logic                    busy,
    output logic                    result_valid,
    output logic [ADC_SAMPLE_W-1:0] result_data,
    output logic [ADC_CH_W-1:0]     result_channel,
    output logic                    scan_done,
    output logic [ADC_NUM_CH-1:0]   timeout_flags,
    input  logic [ADC_CH_W-1:0]     rd_channel,
    output logic [ADC_SAMPLE_W-1:0] rd_data
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       DISC_MAX = 3'(DISCARD);

    adc_scan_state_t         state_q, state_d;
    logic [ADC_NUM_CH-1:0]   mask_q, mask_d;
    logic [ADC_PTR_W-1:0]    ptr_q, ptr_d;
    logic [ADC_CH_W-1:0]     channel_q, channel_d;
    logic [2:0]              disc_q, disc_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [ADC_NUM_CH-1:0]   flags_q, flags_d;
    logic                    rv_q, rv_d;
    logic [ADC_SAMPLE_W-1:0] rdata_q, rdata_d;
    logic [ADC_CH_W-1:0]     rch_q, rch_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    bank_we;
    logic [ADC_SAMPLE_W-1:0] bank [ADC_NUM_CH];

    logic                    found;
    logic [ADC_CH_W-1:0]     found_idx;
    logic                    match;
    logic                    accept;
    logic                    expired;

    adc_ch_finder u_finder (
        .mask  (mask_q),
        .ptr   (ptr_q),
        .found (found),
        .idx   (found_idx)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        channel_d = channel_q;
        disc_d    = disc_q;
        tmo_d     = tmo_q;
        flags_d   = flags_q;
        rv_d      = 1'b0;
        rdata_d   = rdata_q;
        rch_d     = rch_q;
        done_d    = 1'b0;
        bank_we   = 1'b0;

        match   = new_sample && (sample_channel == channel_q);
        accept  = match && (disc_q >= DISC_MAX);
        expired = (tmo_q == '0);

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    mask_d  = ch_enable;
                    ptr_d   = '0;
                    flags_d = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    channel_d = found_idx;
                    disc_d    = '0;
                    tmo_d     = TMO_LOAD;
                    state_d   = WAIT;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                // An accept on the expiry cycle wins over the timeout.
                if (accept) begin
                    bank_we = 1'b1;
                    rv_d    = 1'b1;
                    rdata_d = sample;
                    rch_d   = channel_q;
                    ptr_d   = adc_next_ptr(channel_q);
                    state_d = SELECT;
                end else if (expired) begin
                    flags_d[channel_q] = 1'b1;
                    ptr_d              = adc_next_ptr(channel_q);
                    state_d            = SELECT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                    if (match) begin
                        disc_d = disc_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (scan_continuous) begin
                    mask_d  = ch_enable;
                    ptr_d   = '0;
                    flags_d = '0;
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ptr_q     <= '0;
            channel_q <= '0;
            disc_q    <= '0;
            tmo_q     <= '0;
            flags_q   <= '0;
            rv_q      <= 1'b0;
            rdata_q   <= '0;
            rch_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < ADC_NUM_CH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            channel_q <= channel_d;
            disc_q    <= disc_d;
            tmo_q     <= tmo_d;
            flags_q   <= flags_d;
            rv_q      <= rv_d;
            rdata_q   <= rdata_d;
            rch_q     <= rch_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (bank_we) begin
                bank[channel_q] <= sample;
            end
        end
    end

    assign channel        = channel_q;
    assign busy           = busy_q;
    assign result_valid   = rv_q;
    assign result_data    = rdata_q;
    assign result_channel = rch_q;
    assign scan_done      = done_q;
    assign timeout_flags  = flags_q;
    assign rd_data        = bank[rd_channel];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a result scoreboard.
// Expected results are queued at stimulus time and popped by a monitor.
module tb_adc_scan_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] ch_enable;
    logic        scan_start;
    logic        scan_continuous;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic        busy;
    logic        result_valid;
    logic [9:0]  result_data;
    logic [3:0]  result_channel;
    logic        scan_done;
    logic [15:0] timeout_flags;
    logic [3:0]  rd_channel;
    logic [9:0]  rd_data;

    typedef struct {
        logic [3:0] ch;
        logic [9:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   done_cnt;

    adc_scan_scheduler #(
        .DISCARD        (1),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ch_enable       (ch_enable),
        .scan_start      (scan_start),
        .scan_continuous (scan_continuous),
        .channel         (channel),
        .new_sample      (new_sample),
        .sample          (sample),
        .sample_channel  (sample_channel),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_channel  (result_channel),
        .scan_done       (scan_done),
        .timeout_flags   (timeout_flags),
        .rd_channel      (rd_channel),
        .rd_data         (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe from the AVR side; the sample bus keeps its value afterwards.
    task automatic send(input logic [3:0] ch, input logic [9:0] val);
        new_sample     = 1'b1;
        sample_channel = ch;
        sample         = val;
        tick();
        new_sample     = 1'b0;
    endtask

    task automatic push(input logic [3:0] ch, input logic [9:0] val);
        exp_t e;
        e.ch   = ch;
        e.data = val;
        exp_q.push_back(e);
    endtask

    task automatic start_scan(input logic [15:0] mask);
        ch_enable  = mask;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (scan_done) done_cnt++;
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: actual ch=%0h data=%0h required none",
                             result_channel, result_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result_channel", result_channel, e.ch);
                    check("result_data", result_data, e.data);
                end
            end
        end
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        done_cnt        = 0;
        rst             = 1'b0;
        ch_enable       = '0;
        scan_start      = 1'b0;
        scan_continuous = 1'b0;
        new_sample      = 1'b0;
        sample          = '0;
        sample_channel  = '0;
        rd_channel      = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_channel", channel, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", result_data, 0);
        check("rst_result_channel", result_channel, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_timeout_flags", timeout_flags, 0);
        for (int i = 0; i < 16; i += 5) begin
            rd_channel = 4'(i);
            #1;
            check("rst_bank", rd_data, 0);
        end
        rst = 1'b1;
        tick();

        // Two channels, one dropped sample each
        rd_channel = 4'd0;
        start_scan(16'h0003);
        check("t1_busy_after_start", busy, 1);
        tick();
        check("t1_channel0", channel, 0);
        push(4'd0, 10'h155);
        send(4'd0, 10'h3FF);
        send(4'd0, 10'h155);
        check("t1_rd_same_cycle_ch0", rd_data, 10'h155);
        rd_channel = 4'd1;
        tick();
        check("t1_channel1", channel, 1);
        push(4'd1, 10'h2AA);
        send(4'd1, 10'h111);
        send(4'd1, 10'h2AA);
        check("t1_rd_same_cycle_ch1", rd_data, 10'h2AA);
        tick();
        check("t1_scan_done", scan_done, 1);
        check("t1_busy_in_done", busy, 1);
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_scan_done_after", scan_done, 0);
        rd_channel = 4'd0;
        #1;
        check("t1_rd_ch0", rd_data, 10'h155);

        // Empty mask
        start_scan(16'h0000);
        check("t2_no_done_in_select", scan_done, 0);
        tick();
        check("t2_scan_done", scan_done, 1);
        tick();
        check("t2_busy_after", busy, 0);

        // ch4 answers, ch15 silent and times out; ch14 traffic must not disturb the timer
        rd_channel = 4'd15;
        start_scan(16'h8010);
        tick();
        check("t3_channel4", channel, 4);
        push(4'd4, 10'h0C4);
        send(4'd4, 10'h0AB);
        send(4'd4, 10'h0C4);
        tick();
        check("t3_channel15", channel, 15);
        for (int i = 0; i < 19; i++) begin
            new_sample     = (i < 5);
            sample_channel = 4'd14;
            sample         = 10'h3C3;
            tick();
        end
        new_sample = 1'b0;
        check("t3_flags_before_expiry", timeout_flags, 0);
        check("t3_still_waiting", busy, 1);
        tick();
        check("t3_flags_at_expiry", timeout_flags, 16'h8000);
        check("t3_no_done_yet", scan_done, 0);
        tick();
        check("t3_scan_done", scan_done, 1);
        check("t3_flags_in_done", timeout_flags, 16'h8000);
        check("t3_bank15_unchanged", rd_data, 0);
        tick();

        // Foreign samples ignored; accept on the expiry cycle beats the timeout
        start_scan(16'h0010);
        check("t4_flags_cleared", timeout_flags, 0);
        tick();
        send(4'd4, 10'h001);
        for (int i = 0; i < 5; i++) send(4'd3, 10'h333);
        repeat (13) tick();
        rd_channel = 4'd4;
        push(4'd4, 10'h1A5);
        send(4'd4, 10'h1A5);
        check("t4_flag4_clear", timeout_flags, 0);
        check("t4_rd_ch4", rd_data, 10'h1A5);
        rd_channel = 4'd3;
        #1;
        check("t4_bank3_untouched", rd_data, 0);
        tick();
        check("t4_scan_done", scan_done, 1);
        check("t4_flags_in_done", timeout_flags, 0);
        tick();

        // Continuous scans; mask re-latched at each restart
        scan_continuous = 1'b1;
        start_scan(16'h0001);
        ch_enable = 16'h0002;
        tick();
        check("t5_scan1_channel0", channel, 0);
        push(4'd0, 10'h011);
        send(4'd0, 10'h3AA);
        send(4'd0, 10'h011);
        tick();
        check("t5_scan1_done", scan_done, 1);
        check("t5_busy_in_done", busy, 1);
        tick();
        check("t5_busy_restart", busy, 1);
        check("t5_done_single_pulse", scan_done, 0);
        tick();
        check("t5_scan2_channel1", channel, 1);
        push(4'd1, 10'h022);
        send(4'd1, 10'h3BB);
        send(4'd1, 10'h022);
        scan_continuous = 1'b0;
        tick();
        check("t5_scan2_done", scan_done, 1);
        tick();
        check("t5_busy_after", busy, 0);
        repeat (3) tick();
        check("t5_no_extra_done", scan_done, 0);
        check("t5_idle", busy, 0);

        // Asynchronous reset during WAIT
        start_scan(16'h0004);
        tick();
        check("t6_channel2", channel, 2);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_channel", channel, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_flags", timeout_flags, 0);
        check("t6_rst_result_data", result_data, 0);
        check("t6_rst_result_channel", result_channel, 0);
        for (int i = 0; i < 5; i++) begin
            rd_channel = 4'(i);
            #1;
            check("t6_rst_bank", rd_data, 0);
        end
        tick();
        rst = 1'b1;
        tick();
        rd_channel = 4'd2;
        start_scan(16'h0004);
        check("t6_busy_restart", busy, 1);
        tick();
        check("t6_channel2_again", channel, 2);
        push(4'd2, 10'h2D2);
        send(4'd2, 10'h0F0);
        send(4'd2, 10'h2D2);
        check("t6_rd_ch2", rd_data, 10'h2D2);
        tick();
        check("t6_scan_done", scan_done, 1);
        repeat (2) tick();

        check("sb_pending", exp_q.size(), 0);
        check("scan_done_total", done_cnt, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
